// File: rtl/custom_bm_pkg.sv
`default_nettype none
// ============================================================================
// custom_bm_pkg : shared encodings and widths for the bus-matrix input stage
// Revision 1.0 - initial release
// ============================================================================
package custom_bm_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    // Captured control bits besides the address: write, size, burst, prot, master, mastlock
    localparam int CTRL_W = 1 + 3 + 3 + 4 + 4 + 1;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    typedef enum logic {
        ST_ADDR = 1'b0,
        ST_HELD = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/custom_bm_hold_reg.sv
`default_nettype none
// ============================================================================
// custom_bm_hold_reg : capture-enable register over packed address/control
// Revision 1.0 - initial release
// ============================================================================
module custom_bm_hold_reg
    import custom_bm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_ADDR_W + CTRL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture_en,
    input  logic [WIDTH-1:0] fields_in,
    output logic [WIDTH-1:0] fields_out
);

    logic [WIDTH-1:0] fields_d;
    logic [WIDTH-1:0] fields_q;

    always_comb begin
        fields_d = fields_q;
        if (capture_en) begin
            fields_d = fields_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fields_q <= '0;
        end else begin
            fields_q <= fields_d;
        end
    end

    assign fields_out = fields_q;

endmodule
`default_nettype wire

// File: rtl/custom_bm_input_stage.sv
`default_nettype none
// ============================================================================
// custom_bm_input_stage : AHB master-side input stage that holds a transfer
// until the owning output stage grants it. Revision 1.0 - initial release
// ============================================================================
module custom_bm_input_stage
    import custom_bm_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic [3:0]        HMASTERS,
    input  logic              HMASTLOCKS,
    input  logic [DATA_W-1:0] HWDATAS,
    input  logic              HREADYS,
    output logic              HREADYOUTS,
    output logic [1:0]        HRESPS,
    output logic              sel_op,
    output logic [ADDR_W-1:0] addr_op,
    output logic [1:0]        trans_op,
    output logic              write_op,
    output logic [2:0]        size_op,
    output logic [2:0]        burst_op,
    output logic [3:0]        prot_op,
    output logic [3:0]        master_op,
    output logic              mastlock_op,
    output logic [DATA_W-1:0] wdata_op,
    output logic              held_tran_op,
    input  logic              active_op,
    input  logic              hready_op,
    input  logic [1:0]        hresp_op
);

    localparam int HOLD_W = ADDR_W + CTRL_W;

    state_e             state_d;
    state_e             state_q;
    logic               data_phase_d;
    logic               data_phase_q;
    logic               tran_valid;
    logic               grant;
    logic               err_cancel;
    logic               capture;
    logic [HOLD_W-1:0]  live_fields;
    logic [HOLD_W-1:0]  held_fields;

    logic [ADDR_W-1:0]  h_addr;
    logic               h_write;
    logic [2:0]         h_size;
    logic [2:0]         h_burst;
    logic [3:0]         h_prot;
    logic [3:0]         h_master;
    logic               h_lock;

    // Gating with HRESETn keeps held_tran_op low throughout reset
    assign tran_valid = HSELS & HTRANSS[1] & HREADYS & HRESETn;
    assign grant      = active_op & hready_op;
    assign err_cancel = (state_q == ST_HELD) & data_phase_q
                      & (hresp_op == HRESP_ERROR) & hready_op;

    assign live_fields = {HADDRS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS, HMASTLOCKS};
    assign {h_addr, h_write, h_size, h_burst, h_prot, h_master, h_lock} = held_fields;

    custom_bm_hold_reg #(
        .WIDTH (HOLD_W)
    ) u_hold_reg (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .capture_en (capture),
        .fields_in  (live_fields),
        .fields_out (held_fields)
    );

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_ADDR: begin
                if (tran_valid & ~grant) begin
                    capture = 1'b1;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                // An ERROR on the earlier data phase cancels the held transfer
                if (err_cancel | grant) begin
                    state_d = ST_ADDR;
                end
            end
            default: state_d = ST_ADDR;
        endcase
    end

    always_comb begin
        data_phase_d = data_phase_q;
        if (grant & held_tran_op & ~err_cancel) begin
            data_phase_d = 1'b1;
        end else if (hready_op) begin
            data_phase_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_ADDR;
            data_phase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_phase_q <= data_phase_d;
        end
    end

    assign held_tran_op = (state_q == ST_HELD) | tran_valid;
    assign wdata_op     = HWDATAS;

    always_comb begin
        sel_op      = HSELS;
        addr_op     = HADDRS;
        trans_op    = HTRANSS;
        write_op    = HWRITES;
        size_op     = HSIZES;
        burst_op    = HBURSTS;
        prot_op     = HPROTS;
        master_op   = HMASTERS;
        mastlock_op = HMASTLOCKS;
        if (state_q == ST_HELD) begin
            sel_op      = 1'b1;
            addr_op     = h_addr;
            trans_op    = HTRANS_NONSEQ;
            write_op    = h_write;
            size_op     = h_size;
            burst_op    = h_burst;
            prot_op     = h_prot;
            master_op   = h_master;
            mastlock_op = h_lock;
        end
    end

    always_comb begin
        HREADYOUTS = 1'b1;
        if (state_q == ST_HELD) begin
            HREADYOUTS = 1'b0;
        end else if (data_phase_q) begin
            HREADYOUTS = hready_op;
        end
    end

    assign HRESPS = data_phase_q ? hresp_op : HRESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_custom_bm_input_stage.sv
`default_nettype none
// ============================================================================
// tb_custom_bm_input_stage : vector table, directed corner sequences and a
// randomized run against a transfer-level model. Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_custom_bm_input_stage;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic [3:0]  HMASTERS;
    logic        HMASTLOCKS;
    logic [31:0] HWDATAS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic        sel_op;
    logic [31:0] addr_op;
    logic [1:0]  trans_op;
    logic        write_op;
    logic [2:0]  size_op;
    logic [2:0]  burst_op;
    logic [3:0]  prot_op;
    logic [3:0]  master_op;
    logic        mastlock_op;
    logic [31:0] wdata_op;
    logic        held_tran_op;
    logic        active_op;
    logic        hready_op;
    logic [1:0]  hresp_op;

    int checks = 0;
    int errors = 0;

    custom_bm_input_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS),
        .HWDATAS(HWDATAS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS),
        .HRESPS(HRESPS), .sel_op(sel_op), .addr_op(addr_op), .trans_op(trans_op),
        .write_op(write_op), .size_op(size_op), .burst_op(burst_op),
        .prot_op(prot_op), .master_op(master_op), .mastlock_op(mastlock_op),
        .wdata_op(wdata_op), .held_tran_op(held_tran_op), .active_op(active_op),
        .hready_op(hready_op), .hresp_op(hresp_op)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        HSELS = 1'b0; HADDRS = '0; HTRANSS = 2'b00; HWRITES = 1'b0;
        HSIZES = '0; HBURSTS = '0; HPROTS = '0; HMASTERS = '0; HMASTLOCKS = 1'b0;
        HWDATAS = '0; HREADYS = 1'b1; active_op = 1'b0; hready_op = 1'b1;
        hresp_op = 2'b00;
    endtask

    task automatic xfer(input logic [1:0] tr, input logic [31:0] a, input logic act);
        HSELS = 1'b1; HTRANSS = tr; HADDRS = a; HREADYS = 1'b1; active_op = act;
    endtask

    // Inputs are changed on the falling edge and sampled 1 ns later
    task automatic cyc();
        @(negedge HCLK);
    endtask

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        rdys;
        logic [31:0] addr;
        logic        act;
        logic        e_held;
        logic [1:0]  e_trans;
        logic [31:0] e_addr;
        logic        e_rdy;
    } vec_t;

    vec_t tbl[7];

    // Transfer-level reference: a pending-transfer queue and a data-phase flag
    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic [3:0]  master;
        logic        lock;
    } xfer_t;

    xfer_t pending[$];
    bit    m_dp;

    function automatic logic [86:0] model_outputs();
        logic        tv;
        logic [86:0] o;
        tv = HSELS && HTRANSS[1] && HREADYS;
        if (pending.size() != 0)
            o = {1'b1, pending[0].addr, 2'b10, pending[0].write, pending[0].size,
                 pending[0].burst, pending[0].prot, pending[0].master, pending[0].lock,
                 HWDATAS, 1'b1, 1'b0, (m_dp ? hresp_op : 2'b00)};
        else
            o = {HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS,
                 HMASTLOCKS, HWDATAS, tv, (m_dp ? hready_op : 1'b1),
                 (m_dp ? hresp_op : 2'b00)};
        return o;
    endfunction

    task automatic model_clock();
        bit tv;
        bit granted;
        tv      = HSELS && HTRANSS[1] && HREADYS;
        granted = active_op && hready_op;
        if (pending.size() != 0) begin
            if (m_dp && hresp_op == 2'b01 && hready_op) begin
                void'(pending.pop_front());
                m_dp = 1'b0;
            end else if (granted) begin
                void'(pending.pop_front());
                m_dp = 1'b1;
            end else if (hready_op) begin
                m_dp = 1'b0;
            end
        end else begin
            if (tv && !granted)
                pending.push_back('{HADDRS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS, HMASTLOCKS});
            if (tv && granted) m_dp = 1'b1;
            else if (hready_op) m_dp = 1'b0;
        end
    endtask

    function automatic logic [86:0] dut_outputs();
        return {sel_op, addr_op, trans_op, write_op, size_op, burst_op, prot_op,
                master_op, mastlock_op, wdata_op, held_tran_op, HREADYOUTS, HRESPS};
    endfunction

    initial begin
        tbl[0] = '{1'b1, 2'b10, 1'b1, 32'h2000_0010, 1'b1, 1'b1, 2'b10, 32'h2000_0010, 1'b1};
        tbl[1] = '{1'b1, 2'b00, 1'b1, 32'h1111_0000, 1'b1, 1'b0, 2'b00, 32'h1111_0000, 1'b1};
        tbl[2] = '{1'b1, 2'b01, 1'b1, 32'h2222_0000, 1'b1, 1'b0, 2'b01, 32'h2222_0000, 1'b1};
        tbl[3] = '{1'b1, 2'b11, 1'b1, 32'h0000_0104, 1'b1, 1'b1, 2'b11, 32'h0000_0104, 1'b1};
        tbl[4] = '{1'b0, 2'b10, 1'b1, 32'h3333_0000, 1'b1, 1'b0, 2'b10, 32'h3333_0000, 1'b1};
        tbl[5] = '{1'b1, 2'b10, 1'b0, 32'h4444_0000, 1'b1, 1'b0, 2'b10, 32'h4444_0000, 1'b1};
        tbl[6] = '{1'b1, 2'b00, 1'b1, 32'h5555_0000, 1'b0, 1'b0, 2'b00, 32'h5555_0000, 1'b1};

        // Reset state, with a valid transfer presented on the inputs
        set_idle();
        HRESETn = 1'b0;
        xfer(2'b10, 32'h2000_0010, 1'b0);
        cyc(); #1;
        chk("reset_hreadyout", HREADYOUTS, 1'b1);
        chk("reset_hresp", HRESPS, 2'b00);
        chk("reset_held_tran", held_tran_op, 1'b0);
        cyc();
        set_idle();
        HRESETn = 1'b1;

        // Table: single-cycle behaviour from ADDR with no slave stall
        for (int i = 0; i < 7; i++) begin
            cyc();
            set_idle();
            HSELS = tbl[i].sel; HTRANSS = tbl[i].trans; HREADYS = tbl[i].rdys;
            HADDRS = tbl[i].addr; active_op = tbl[i].act;
            #1;
            chk($sformatf("tbl%0d_held_tran", i), held_tran_op, tbl[i].e_held);
            chk($sformatf("tbl%0d_trans", i), trans_op, tbl[i].e_trans);
            chk($sformatf("tbl%0d_addr", i), addr_op, tbl[i].e_addr);
            chk($sformatf("tbl%0d_hreadyout", i), HREADYOUTS, tbl[i].e_rdy);
        end
        cyc(); set_idle(); #1;
        chk("idle_no_capture", HREADYOUTS, 1'b1);

        // Granted NONSEQ: data phase follows, observed through a slave stall
        cyc(); set_idle(); xfer(2'b10, 32'h2000_0010, 1'b1); #1;
        chk("grant_held_tran", held_tran_op, 1'b1);
        chk("grant_hreadyout", HREADYOUTS, 1'b1);
        cyc(); set_idle(); hready_op = 1'b0; #1;
        chk("grant_data_phase", HREADYOUTS, 1'b0);
        cyc(); set_idle();

        // Contention: denied for three cycles, address changes underneath
        cyc(); xfer(2'b10, 32'h2000_0010, 1'b0); #1;
        chk("cont_first_ready", HREADYOUTS, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc(); HADDRS = 32'hDEAD_BEEF; HREADYS = 1'b0; active_op = (k == 2); #1;
            chk($sformatf("cont%0d_hreadyout", k), HREADYOUTS, 1'b0);
            chk($sformatf("cont%0d_addr", k), addr_op, 32'h2000_0010);
            chk($sformatf("cont%0d_held_tran", k), held_tran_op, 1'b1);
        end
        cyc(); set_idle(); HADDRS = 32'h0BAD_0000; #1;
        chk("cont_after_ready", HREADYOUTS, 1'b1);
        chk("cont_after_addr", addr_op, 32'h0BAD_0000);
        chk("cont_after_held", held_tran_op, 1'b0);

        // SEQ captured while denied is replayed as NONSEQ
        cyc(); set_idle(); xfer(2'b11, 32'h0000_0104, 1'b0); #1;
        chk("seq_live_trans", trans_op, 2'b11);
        cyc(); HREADYS = 1'b0; active_op = 1'b1; #1;
        chk("seq_held_trans", trans_op, 2'b10);
        chk("seq_held_addr", addr_op, 32'h0000_0104);
        chk("seq_held_sel", sel_op, 1'b1);
        cyc(); set_idle(); #1;
        chk("seq_released", HREADYOUTS, 1'b1);

        // ERROR on the data phase cancels a transfer held meanwhile
        cyc(); set_idle(); xfer(2'b10, 32'h0000_1000, 1'b1);
        cyc(); xfer(2'b10, 32'h0000_2000, 1'b0); hready_op = 1'b0; hresp_op = 2'b01; #1;
        chk("err1_hresp", HRESPS, 2'b01);
        chk("err1_hreadyout", HREADYOUTS, 1'b0);
        cyc(); HREADYS = 1'b0; hready_op = 1'b1; #1;
        chk("err2_hresp", HRESPS, 2'b01);
        chk("err2_held", held_tran_op, 1'b1);
        cyc(); set_idle(); hresp_op = 2'b01; #1;
        chk("err_after_held", held_tran_op, 1'b0);
        chk("err_after_ready", HREADYOUTS, 1'b1);
        chk("err_after_resp", HRESPS, 2'b00);

        // Asynchronous reset while holding
        cyc(); set_idle(); xfer(2'b10, 32'h0000_3000, 1'b0);
        cyc(); #1;
        chk("rst_pre_held", HREADYOUTS, 1'b0);
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_async_ready", HREADYOUTS, 1'b1);
        chk("rst_async_held", held_tran_op, 1'b0);
        cyc(); set_idle(); HRESETn = 1'b1; #1;
        chk("rst_after_ready", HREADYOUTS, 1'b1);

        // Randomized traffic against the reference model
        pending.delete();
        m_dp = 1'b0;
        for (int n = 0; n < 800; n++) begin
            cyc();
            HSELS      = ($urandom_range(0, 3) != 0);
            HTRANSS    = 2'($urandom);
            HREADYS    = ($urandom_range(0, 3) != 0);
            HADDRS     = $urandom;
            HWRITES    = 1'($urandom);
            HSIZES     = 3'($urandom);
            HBURSTS    = 3'($urandom);
            HPROTS     = 4'($urandom);
            HMASTERS   = 4'($urandom);
            HMASTLOCKS = 1'($urandom);
            HWDATAS    = $urandom;
            active_op  = ($urandom_range(0, 2) == 0);
            hready_op  = ($urandom_range(0, 3) != 0);
            hresp_op   = ($urandom_range(0, 3) == 0) ? 2'b01 : 2'b00;
            #1;
            chk($sformatf("rand%0d_outputs", n), dut_outputs(), model_outputs());
            model_clock();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/custom_bm_input_stage.md
CUSTOM_BM_INPUT_STAGE -- requirements
Module: custom_bm_input_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning write-data width.
REQ-003 SHALL have port HCLK  input  1  system clock; one clock, all state on its rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have master-side inputs HSELS 1, HADDRS ADDR_W, HTRANSS 2, HWRITES 1, HSIZES 3, HBURSTS 3, HPROTS 4, HMASTERS 4, HMASTLOCKS 1, HWDATAS DATA_W, HREADYS 1; these are standard AHB master-side signals.
REQ-006 SHALL have master-side outputs HREADYOUTS 1 (ready response) and HRESPS 2 (response).
REQ-007 SHALL have outputs to the output stages: sel_op 1, addr_op ADDR_W, trans_op 2, write_op 1, size_op 3, burst_op 3, prot_op 4, master_op 4, mastlock_op 1, wdata_op DATA_W, held_tran_op 1.
REQ-008 SHALL have inputs from the output stages: active_op 1 (arbiter granted this port), hready_op 1 (HREADYMUX of the owning output stage), hresp_op 2 (slave response).

Function
REQ-009 SHALL compute tran_valid = HSELS & HTRANSS[1] & HREADYS. This marks a NONSEQ/SEQ address phase that the master has presented.
REQ-010 SHALL keep a state register with states ADDR (no held transfer) and HELD (transfer captured, awaiting grant).
REQ-011 In ADDR, SHALL capture all address/control fields and go to HELD when tran_valid & ~(active_op & hready_op).
REQ-012 In HELD, SHALL return to ADDR when active_op & hready_op.
REQ-013 SHALL drive held_tran_op = (state==HELD) | tran_valid.
REQ-014 SHALL drive the address/control outputs from the holding register in HELD and from the live HxxxS inputs in ADDR.
REQ-015 In HELD, sel_op SHALL be 1.
REQ-016 In HELD, trans_op SHALL be NONSEQ (2'b10) even when a SEQ was captured.
REQ-017 SHALL pass wdata_op = HWDATAS combinationally, with no register.
REQ-018 SHALL keep a data_phase flag:
- set on the edge where active_op & held_tran_op & hready_op;
- else clear when hready_op.
REQ-019 SHALL drive HREADYOUTS as follows:
- 0 in HELD;
- else hready_op when data_phase;
- else 1.
REQ-020 SHALL drive HRESPS = hresp_op when data_phase, else OKAY (2'b00).
REQ-021 SHALL handle an ERROR response (hresp_op==ERROR) while in HELD as follows: the held transfer is cancelled, with HELD -> ADDR at the second ERROR cycle (hready_op=1), and no grant is consumed.
REQ-022 SHALL neither capture nor hold IDLE/BUSY transfers; BUSY passes through live with held_tran_op=0.
REQ-023 When tran_valid and active_op & hready_op occur in the same cycle, SHALL go straight through with no hold and no wait state.

Reset
REQ-024 On HRESETn low, SHALL set state=ADDR, data_phase=0 and the holding register to all zeros.
REQ-025 During reset, outputs SHALL be HREADYOUTS=1, HRESPS=OKAY and held_tran_op=0.
REQ-026 Reset asserted mid-HELD SHALL discard the held transfer with no output glitch beyond the async clear.

Structure
REQ-027 SHALL put the following in the shared package custom_bm_pkg:
- HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ);
- HRESP encodings (OKAY/ERROR);
- the state enum;
- default ADDR_W/DATA_W.
REQ-028 SHALL implement the holding register as sub-module custom_bm_hold_reg: a capture-enable register over the packed address/control fields.

Verification
REQ-029 Scenario, single NONSEQ with grant: HSELS=1, HTRANSS=NONSEQ, HADDRS=0x2000_0010, active_op=1, hready_op=1. Required: held_tran_op=1, addr_op=0x2000_0010, no HELD, HREADYOUTS=1, data_phase=1 next cycle.
REQ-030 Scenario, contention: same stimulus with active_op=0 for 3 cycles, then 1. Required: HELD for 3 cycles, HREADYOUTS=0 each cycle, addr_op holds 0x2000_0010 after HADDRS changes, ADDR after grant.
REQ-031 Scenario, SEQ held: SEQ to 0x104 captured while denied. Required: trans_op=2'b10 while HELD; passes as 2'b11 when not held.
REQ-032 Scenario, ERROR during HELD: data_phase=1, hresp_op=ERROR with hready_op 0 then 1, new transfer held. Required: HRESPS=ERROR for both cycles, state returns to ADDR, held_tran_op=0 after.
REQ-033 Scenario, reset in HELD: assert HRESETn=0 in HELD. Required: state=ADDR, HREADYOUTS=1, held_tran_op=0 immediately (asynchronously).
REQ-034 Scenario, IDLE/BUSY: HTRANSS=IDLE or BUSY with HSELS=1. Required: held_tran_op=0, no capture, HREADYOUTS=1.
